// File: rtl/ros2_eth_rx_adapter.sv
// rtl/ros2_eth_rx_adapter.sv - IP RX header/payload to byte FIFO adapter
// Rebuilds the 20-byte IPv4 header, then pads or truncates the payload to ip_length-20.
module ros2_eth_rx_adapter #(
    parameter int IP_HDR_SIZE = 20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_rx_hdr_valid,
    output logic        o_rx_hdr_ready,
    input  logic [5:0]  i_rx_ip_dscp,
    input  logic [1:0]  i_rx_ip_ecn,
    input  logic [15:0] i_rx_ip_length,
    input  logic [15:0] i_rx_ip_identification,
    input  logic [2:0]  i_rx_ip_flags,
    input  logic [12:0] i_rx_ip_fragment_offset,
    input  logic [7:0]  i_rx_ip_ttl,
    input  logic [7:0]  i_rx_ip_protocol,
    input  logic [15:0] i_rx_ip_hdr_checksum,
    input  logic [31:0] i_rx_ip_source_ip,
    input  logic [31:0] i_rx_ip_dest_ip,
    input  logic        i_rx_payload_tvalid,
    output logic        o_rx_payload_tready,
    input  logic [7:0]  i_rx_payload_tdata,
    input  logic        i_rx_payload_tlast,
    output logic [7:0]  o_dout_data,
    input  logic        i_dout_full_n,
    output logic        o_dout_wr_en
);
    localparam logic [15:0] HDR_LEN  = 16'(IP_HDR_SIZE);
    localparam logic [4:0]  HDR_LAST = 5'(IP_HDR_SIZE - 1);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_PAD, S_DRAIN} state_t;

    state_t      state;
    logic [4:0]  offset;
    logic [15:0] counter;
    logic [15:0] len;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] ip_length;
    logic [15:0] ident;
    logic [2:0]  flags;
    logic [12:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] checksum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [7:0]  hdr_byte;
    logic        active;
    logic [15:0] cnt_next;

    // Gating with reset as well keeps hdr_ready low while reset is held.
    assign active   = i_rst_n & i_enable;
    assign cnt_next = counter + 16'd1;

    always_comb begin
        hdr_byte = 8'h00;
        case (offset)
            5'd0:  hdr_byte = 8'h45;
            5'd1:  hdr_byte = {dscp, ecn};
            5'd2:  hdr_byte = ip_length[15:8];
            5'd3:  hdr_byte = ip_length[7:0];
            5'd4:  hdr_byte = ident[15:8];
            5'd5:  hdr_byte = ident[7:0];
            5'd6:  hdr_byte = {flags, frag_off[12:8]};
            5'd7:  hdr_byte = frag_off[7:0];
            5'd8:  hdr_byte = ttl;
            5'd9:  hdr_byte = protocol;
            5'd10: hdr_byte = checksum[15:8];
            5'd11: hdr_byte = checksum[7:0];
            5'd12: hdr_byte = src_ip[31:24];
            5'd13: hdr_byte = src_ip[23:16];
            5'd14: hdr_byte = src_ip[15:8];
            5'd15: hdr_byte = src_ip[7:0];
            5'd16: hdr_byte = dst_ip[31:24];
            5'd17: hdr_byte = dst_ip[23:16];
            5'd18: hdr_byte = dst_ip[15:8];
            5'd19: hdr_byte = dst_ip[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        o_rx_hdr_ready      = 1'b0;
        o_rx_payload_tready = 1'b0;
        o_dout_wr_en        = 1'b0;
        o_dout_data         = 8'h00;
        case (state)
            S_IDLE: o_rx_hdr_ready = active;
            S_HDR: begin
                o_dout_data  = hdr_byte;
                o_dout_wr_en = active & i_dout_full_n;
            end
            S_PAYLOAD: begin
                o_dout_data         = i_rx_payload_tdata;
                o_rx_payload_tready = active & i_dout_full_n;
                o_dout_wr_en        = active & i_rx_payload_tvalid & i_dout_full_n;
            end
            S_PAD:   o_dout_wr_en = active & i_dout_full_n;
            S_DRAIN: o_rx_payload_tready = active;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            offset    <= '0;
            counter   <= '0;
            len       <= '0;
            dscp      <= '0;
            ecn       <= '0;
            ip_length <= '0;
            ident     <= '0;
            flags     <= '0;
            frag_off  <= '0;
            ttl       <= '0;
            protocol  <= '0;
            checksum  <= '0;
            src_ip    <= '0;
            dst_ip    <= '0;
        end else if (!i_enable) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (i_rx_hdr_valid) begin
                    dscp      <= i_rx_ip_dscp;
                    ecn       <= i_rx_ip_ecn;
                    ip_length <= i_rx_ip_length;
                    ident     <= i_rx_ip_identification;
                    flags     <= i_rx_ip_flags;
                    frag_off  <= i_rx_ip_fragment_offset;
                    ttl       <= i_rx_ip_ttl;
                    protocol  <= i_rx_ip_protocol;
                    checksum  <= i_rx_ip_hdr_checksum;
                    src_ip    <= i_rx_ip_source_ip;
                    dst_ip    <= i_rx_ip_dest_ip;
                    offset    <= '0;
                    counter   <= '0;
                    if (i_rx_ip_length < HDR_LEN) begin
                        len   <= '0;
                        state <= S_DRAIN;
                    end else begin
                        len   <= i_rx_ip_length - HDR_LEN;
                        state <= S_HDR;
                    end
                end
                S_HDR: if (o_dout_wr_en) begin
                    if (offset == HDR_LAST) begin
                        offset <= '0;
                        state  <= (len != 16'd0) ? S_PAYLOAD : S_DRAIN;
                    end else begin
                        offset <= offset + 5'd1;
                    end
                end
                S_PAYLOAD: if (o_dout_wr_en) begin
                    counter <= cnt_next;
                    if (cnt_next == len)
                        state <= i_rx_payload_tlast ? S_IDLE : S_DRAIN;
                    else if (i_rx_payload_tlast)
                        state <= S_PAD;
                end
                S_PAD: if (o_dout_wr_en) begin
                    counter <= cnt_next;
                    if (cnt_next == len)
                        state <= S_IDLE;
                end
                S_DRAIN: if (i_rx_payload_tvalid && i_rx_payload_tlast)
                    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ros2_eth_rx_adapter.sv
// tb/tb_ros2_eth_rx_adapter.sv - randomized self-checking bench for ros2_eth_rx_adapter
module tb_ros2_eth_rx_adapter;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_enable = 1'b1;
    logic        i_rx_hdr_valid = 1'b0;
    logic        o_rx_hdr_ready;
    logic [5:0]  i_rx_ip_dscp = '0;
    logic [1:0]  i_rx_ip_ecn = '0;
    logic [15:0] i_rx_ip_length = '0;
    logic [15:0] i_rx_ip_identification = '0;
    logic [2:0]  i_rx_ip_flags = '0;
    logic [12:0] i_rx_ip_fragment_offset = '0;
    logic [7:0]  i_rx_ip_ttl = '0;
    logic [7:0]  i_rx_ip_protocol = '0;
    logic [15:0] i_rx_ip_hdr_checksum = '0;
    logic [31:0] i_rx_ip_source_ip = '0;
    logic [31:0] i_rx_ip_dest_ip = '0;
    logic        i_rx_payload_tvalid = 1'b0;
    logic        o_rx_payload_tready;
    logic [7:0]  i_rx_payload_tdata = '0;
    logic        i_rx_payload_tlast = 1'b0;
    logic [7:0]  o_dout_data;
    logic        i_dout_full_n = 1'b1;
    logic        o_dout_wr_en;

    ros2_eth_rx_adapter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
        .i_rx_hdr_valid(i_rx_hdr_valid), .o_rx_hdr_ready(o_rx_hdr_ready),
        .i_rx_ip_dscp(i_rx_ip_dscp), .i_rx_ip_ecn(i_rx_ip_ecn),
        .i_rx_ip_length(i_rx_ip_length), .i_rx_ip_identification(i_rx_ip_identification),
        .i_rx_ip_flags(i_rx_ip_flags), .i_rx_ip_fragment_offset(i_rx_ip_fragment_offset),
        .i_rx_ip_ttl(i_rx_ip_ttl), .i_rx_ip_protocol(i_rx_ip_protocol),
        .i_rx_ip_hdr_checksum(i_rx_ip_hdr_checksum), .i_rx_ip_source_ip(i_rx_ip_source_ip),
        .i_rx_ip_dest_ip(i_rx_ip_dest_ip), .i_rx_payload_tvalid(i_rx_payload_tvalid),
        .o_rx_payload_tready(o_rx_payload_tready), .i_rx_payload_tdata(i_rx_payload_tdata),
        .i_rx_payload_tlast(i_rx_payload_tlast), .o_dout_data(o_dout_data),
        .i_dout_full_n(i_dout_full_n), .o_dout_wr_en(o_dout_wr_en)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_while_full = 0;
    bit hdr_acc = 0;
    bit back_idle = 0;
    logic [7:0] pl_src[$];
    logic [7:0] pl_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Reference: the FIFO sees the 20 header bytes then exactly length-20 payload bytes, zero filled.
    task automatic build_expected();
        logic [7:0] h[20];
        int plen;
        exp_q.delete();
        if (i_rx_ip_length < 16'd20) return;
        h[0] = 8'h45;
        h[1] = i_rx_ip_dscp * 4 + i_rx_ip_ecn;
        h[2] = 8'(i_rx_ip_length / 256);            h[3] = 8'(i_rx_ip_length % 256);
        h[4] = 8'(i_rx_ip_identification / 256);    h[5] = 8'(i_rx_ip_identification % 256);
        h[6] = 8'(i_rx_ip_flags * 32 + i_rx_ip_fragment_offset / 256);
        h[7] = 8'(i_rx_ip_fragment_offset % 256);
        h[8] = i_rx_ip_ttl;                         h[9] = i_rx_ip_protocol;
        h[10] = 8'(i_rx_ip_hdr_checksum / 256);     h[11] = 8'(i_rx_ip_hdr_checksum % 256);
        for (int i = 0; i < 4; i++) begin
            h[12+i] = 8'(i_rx_ip_source_ip >> (24 - 8*i));
            h[16+i] = 8'(i_rx_ip_dest_ip >> (24 - 8*i));
        end
        for (int i = 0; i < 20; i++) exp_q.push_back(h[i]);
        plen = int'(i_rx_ip_length) - 20;
        for (int i = 0; i < plen; i++)
            exp_q.push_back(i < pl_src.size() ? pl_src[i] : 8'h00);
    endtask

    task automatic random_header();
        i_rx_ip_dscp = 6'($urandom);            i_rx_ip_ecn = 2'($urandom);
        i_rx_ip_identification = 16'($urandom); i_rx_ip_flags = 3'($urandom);
        i_rx_ip_fragment_offset = 13'($urandom); i_rx_ip_ttl = 8'($urandom);
        i_rx_ip_protocol = 8'($urandom);        i_rx_ip_hdr_checksum = 16'($urandom);
        i_rx_ip_source_ip = $urandom;           i_rx_ip_dest_ip = $urandom;
    endtask

    task automatic random_payload(input int n);
        pl_src.delete();
        for (int i = 0; i < n; i++) pl_src.push_back(8'($urandom));
    endtask

    task automatic drive_inputs(input int full_mode, input bit consumed);
        if (pl_q.size() == 0) begin
            i_rx_payload_tvalid = 1'b0;
            i_rx_payload_tlast  = 1'b0;
        end else begin
            if (!i_rx_payload_tvalid || consumed) i_rx_payload_tvalid = ($urandom_range(3) != 0);
            i_rx_payload_tdata = pl_q[0];
            i_rx_payload_tlast = (pl_q.size() == 1);
        end
        case (full_mode)
            0: i_dout_full_n = 1'b1;
            1: i_dout_full_n = ((cyc / 3) % 2) == 0;
            default: i_dout_full_n = ($urandom_range(9) < 7);
        endcase
    endtask

    task automatic start_packet(input int full_mode);
        pl_q = pl_src;
        got_q.delete();
        hdr_acc = 0; back_idle = 0; wr_while_full = 0; cyc = 0;
        build_expected();
        i_rx_hdr_valid = 1'b1;
        i_rx_payload_tvalid = 1'b0;
        drive_inputs(full_mode, 1'b0);
    endtask

    // Sample at negedge (outputs settled), update inputs 1 time unit after posedge.
    task automatic step(input int full_mode);
        bit consumed;
        @(negedge i_clk);
        if (hdr_acc && o_rx_hdr_ready) back_idle = 1;
        if (i_rx_hdr_valid && o_rx_hdr_ready) hdr_acc = 1;
        consumed = i_rx_payload_tvalid && o_rx_payload_tready;
        if (consumed) void'(pl_q.pop_front());
        if (o_dout_wr_en) begin
            got_q.push_back(o_dout_data);
            if (!i_dout_full_n) wr_while_full++;
        end
        @(posedge i_clk);
        #1;
        cyc++;
        if (hdr_acc) i_rx_hdr_valid = 1'b0;
        drive_inputs(full_mode, consumed);
    endtask

    task automatic run_packet(input string name, input int full_mode);
        start_packet(full_mode);
        while (!back_idle && cyc < 3000) step(full_mode);
        n_checks++;
        if (!back_idle) begin
            n_fail++; $display("FAIL %s timeout: idle=%0d required 1", name, back_idle);
        end
        n_checks++;
        if (pl_q.size() != 0) begin
            n_fail++; $display("FAIL %s payload_left: %0d required 0", name, pl_q.size());
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL %s write_count: %0d required %0d", name, got_q.size(), exp_q.size());
        end
        n_checks++;
        if (wr_while_full != 0) begin
            n_fail++; $display("FAIL %s wr_while_full: %0d required 0", name, wr_while_full);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL %s byte[%0d]: %h required %h", name, i, got_q[i], exp_q[i]);
            end
        end
        i_rx_payload_tvalid = 1'b0;
        i_dout_full_n = 1'b1;
    endtask

    task automatic check_quiet(input string name);
        n_checks++;
        if ({o_rx_hdr_ready, o_rx_payload_tready, o_dout_wr_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s outputs: hdr_ready=%b tready=%b wr_en=%b required 000",
                     name, o_rx_hdr_ready, o_rx_payload_tready, o_dout_wr_en);
        end
    endtask

    task automatic test_reset();
        i_rx_hdr_valid = 1'b1; i_rx_ip_length = 16'd24;
        repeat (2) @(posedge i_clk);
        #1;
        check_quiet("reset");
        n_checks++;
        if (o_dout_data !== 8'h00) begin
            n_fail++; $display("FAIL reset dout_data: %h required 00", o_dout_data);
        end
        i_rx_hdr_valid = 1'b0;
        i_rst_n = 1'b1;
        #1;
        n_checks++;
        if (o_rx_hdr_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release hdr_ready: %b required 1", o_rx_hdr_ready);
        end
    endtask

    task automatic test_basic(input string name, input int full_mode);
        random_header();
        i_rx_ip_length = 16'd24; i_rx_ip_ttl = 8'h40; i_rx_ip_protocol = 8'h11;
        i_rx_ip_source_ip = 32'h0A000001; i_rx_ip_dest_ip = 32'h0A000002;
        pl_src = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_packet(name, full_mode);
    endtask

    task automatic test_sized(input string name, input int length, input int n);
        random_header();
        i_rx_ip_length = 16'(length);
        random_payload(n);
        run_packet(name, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            random_header();
            i_rx_ip_length = 16'($urandom_range(45));
            random_payload($urandom_range(30, 1));
            run_packet($sformatf("random%0d", k), 2);
        end
    endtask

    task automatic test_enable_drop();
        random_header();
        i_rx_ip_length = 16'd30;
        random_payload(10);
        start_packet(0);
        while (got_q.size() < 23 && cyc < 500) step(0);
        i_enable = 1'b0;
        #1;
        check_quiet("enable_low");
        @(posedge i_clk);
        #1;
        check_quiet("enable_low_next");
        i_rx_hdr_valid = 1'b0; i_rx_payload_tvalid = 1'b0;
        i_enable = 1'b1;
        #1;
        n_checks++;
        if (o_rx_hdr_ready !== 1'b1) begin
            n_fail++; $display("FAIL enable_drop idle: hdr_ready=%b required 1", o_rx_hdr_ready);
        end
    endtask

    task automatic test_reset_mid_header();
        random_header();
        i_rx_ip_length = 16'd28;
        random_payload(8);
        start_packet(0);
        while (got_q.size() < 5 && cyc < 500) step(0);
        i_rst_n = 1'b0;
        #1;
        check_quiet("reset_mid_header");
        n_checks++;
        if (o_dout_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_mid_header dout_data: %h required 00", o_dout_data);
        end
        i_rx_hdr_valid = 1'b0; i_rx_payload_tvalid = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        #1;
        n_checks++;
        if (o_rx_hdr_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_header idle: hdr_ready=%b required 1", o_rx_hdr_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic("basic24", 0);
        test_sized("len20", 20, 1);
        test_sized("pad26", 26, 3);
        test_sized("trunc22", 22, 5);
        test_basic("full_toggle", 1);
        test_sized("short10", 10, 4);
        test_sized("len0", 0, 2);
        test_random();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_header();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++)
            test_sized($sformatf("b2b%0d", k), 20 + k * 3, k * 2 + 1);
    endtask
endmodule

// File: doc/ros2_eth_rx_adapter.md
Name: ros2_eth_rx_adapter

Overview:
RX counterpart of the IP TX adapter. It sits between the IP stack's RX header/payload streams and the ROS2 core's byte-wide input FIFO. It accepts one IP header (parsed fields) plus its AXI-stream payload, rebuilds a raw 20-byte IPv4 header, and writes header and payload bytes into the FIFO as one contiguous packet. Payload length is forced to exactly (ip_length - 20) bytes by zero padding or truncation.

Parameters:
IP_HDR_SIZE, 20, fixed IPv4 header size in bytes; IHL is always emitted as 5.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  block enable; low forces IDLE
i_rx_hdr_valid  in  1  header valid from IP stack
o_rx_hdr_ready  out  1  header accept
i_rx_ip_dscp  in  6  DSCP
i_rx_ip_ecn  in  2  ECN
i_rx_ip_length  in  16  IP total length, header included
i_rx_ip_identification  in  16  ID
i_rx_ip_flags  in  3  flags
i_rx_ip_fragment_offset  in  13  fragment offset
i_rx_ip_ttl  in  8  TTL
i_rx_ip_protocol  in  8  protocol
i_rx_ip_hdr_checksum  in  16  header checksum, passed through unchanged
i_rx_ip_source_ip  in  32  source address
i_rx_ip_dest_ip  in  32  destination address
i_rx_payload_tvalid  in  1  payload valid
o_rx_payload_tready  out  1  payload ready
i_rx_payload_tdata  in  8  payload byte
i_rx_payload_tlast  in  1  last payload byte
o_dout_data  out  8  FIFO write data
i_dout_full_n  in  1  FIFO not full
o_dout_wr_en  out  1  FIFO write strobe

Behaviour:
- Reset (async, active-low): state IDLE, all counters and latched header fields 0. Outputs: o_rx_hdr_ready=0, o_rx_payload_tready=0, o_dout_wr_en=0, o_dout_data=0.
- When i_enable is low, the block goes to IDLE on the next clock and all ready and write outputs are 0. A packet aborted mid-transfer is left partial in the FIFO; this is accepted behaviour.
- All outputs are combinational from state, registers and inputs. There are no output pipeline registers.
- IDLE: o_rx_hdr_ready = i_enable. On hdr_valid & hdr_ready:
  - latch all header fields and set offset=0, counter=0, len = length-20;
  - if length < 20, go to DRAIN; otherwise go to HDR.
- HDR: o_dout_data = header byte[offset], o_dout_wr_en = i_dout_full_n. offset advances only when a write occurs. At offset 19 with a write: go to PAYLOAD if len != 0, else DRAIN.
- Header byte map:
  - 0: 0x45
  - 1: {dscp, ecn}
  - 2-3: length MSB first
  - 4-5: identification
  - 6: {flags, frag_off[12:8]}
  - 7: frag_off[7:0]
  - 8: ttl
  - 9: protocol
  - 10-11: checksum
  - 12-15: source_ip MSB first
  - 16-19: dest_ip MSB first
- PAYLOAD: tready = i_dout_full_n, wr_en = tvalid & full_n, dout_data = tdata. counter increments on each write. Exit rules:
  - counter+1 == len and tlast on the same write: go to IDLE.
  - counter+1 == len without tlast: go to DRAIN (truncate).
  - tlast with counter+1 < len: go to PAD.
- PAD: dout_data = 0x00, wr_en = full_n, tready = 0. counter increments per write. When counter+1 == len with a write, go to IDLE.
- DRAIN: tready = 1, wr_en = 0. On tvalid & tlast, go to IDLE. The payload stream is always assumed to end with tlast.
- A full FIFO (full_n=0) stalls every state that writes. There are no lost or duplicated bytes.
- Arithmetic: len and counter are 16-bit. len is computed only after the length >= 20 check, so it never underflows.
- Only one packet is in flight. hdr_ready is never asserted outside IDLE.

Test Plan:
- Length=24, ttl=0x40, proto=0x11, src=0x0A000001, dst=0x0A000002, 4 payload bytes AA BB CC DD with tlast on DD -> FIFO receives 45,tos,00,18,...,40,11,..,0A,00,00,01,0A,00,00,02,AA,BB,CC,DD (24 writes), then back to IDLE.
- Length=20 with a 1-beat payload (tlast) -> 20 header bytes written, payload beat drained, and no 21st write.
- Length=26, payload of 3 bytes with tlast on the 3rd -> 3 payload bytes followed by 3 bytes of 0x00, 26 writes total.
- Length=22, payload of 5 bytes -> 2 payload bytes written, remaining 3 consumed with tready=1 and no writes.
- i_dout_full_n toggling 0/1 every 3 cycles during the first scenario -> identical 24-byte sequence, and wr_en never high while full_n=0.
- Length=10 -> zero FIFO writes, payload drained to tlast. Separately, i_enable dropped mid-payload -> IDLE next cycle, all readies 0. Separately, i_rst_n asserted mid-header -> outputs 0 immediately.
